// File: rtl/sseg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module : sseg_scan_driver_pkg
// Brief  : Shared constants, FSM encoding and helper functions for the
//          seven-segment scan driver and its BCD conversion engine.
// Rev    : 1.0  initial release
// ============================================================================
package sseg_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_WIDTH  = 13;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_driver_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential shift-add-3 binary to 4-digit BCD converter; re-converts
//          whenever the input differs from the last captured value.
// Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import sseg_scan_driver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] bin_in,
    output logic [15:0]      bcd_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t      state_q;
    logic [WIDTH-1:0] last_bin_q;
    logic [WIDTH-1:0] shift_q;
    logic [15:0]      scratch_q;
    logic [15:0]      bcd_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic [11:0]      adj_d;
    logic [15:0]      scratch_d;
    logic [WIDTH-1:0] shift_d;

    // The thousands nibble never reaches 5 before the final shift for any
    // value up to 8191, so only the lower three nibbles need the adjust.
    always_comb begin
        adj_d = '0;
        for (int k = 0; k < 3; k++) begin
            adj_d[4*k +: 4] = add3_nibble(scratch_q[4*k +: 4]);
        end
        scratch_d = {scratch_q[14:12], adj_d, shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            last_bin_q <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bin_in != last_bin_q) begin
                        shift_q    <= bin_in;
                        last_bin_q <= bin_in;
                        scratch_q  <= '0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_q   <= scratch_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd_out = bcd_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : sseg_scan_driver
// Brief  : BCD conversion plus 4-digit common-anode multiplexed display scan.
//          Optional macro SSEG_LZ_BLANK_EN blanks leading zero digits.
// Rev    : 1.0  initial release
// ============================================================================
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int REFRESH_BITS = 17
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] bin_in,
    output logic [7:0]       seg,
    output logic [3:0]       an,
    output logic [15:0]      bcd_out,
    output logic             busy
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
            $error("sseg_scan_driver: WIDTH must be in 1..13");
        end
    endgenerate

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .CLK     (CLK),
        .RST     (RST),
        .bin_in  (bin_in),
        .bcd_out (bcd_out),
        .busy    (busy)
    );

    logic [REFRESH_BITS-1:0] prescaler_q, prescaler_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [3:0]              an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    tick;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   lit;

`ifdef SSEG_LZ_BLANK_EN
    // A digit stays lit if it or any more significant digit is nonzero.
    always_comb begin
        lit    = '0;
        lit[3] = |bcd_out[15:12];
        lit[2] = lit[3] | (|bcd_out[11:8]);
        lit[1] = lit[2] | (|bcd_out[7:4]);
        lit[0] = 1'b1;
    end
`else
    assign lit = '1;
`endif

    always_comb begin
        prescaler_d = prescaler_q + REFRESH_BITS'(1);
        tick        = &prescaler_q;
        digit_idx_d = tick ? digit_idx_q + IDX_W'(1) : digit_idx_q;
        cur_nib     = bcd_out[{digit_idx_q, 2'b00} +: 4];
        an_d        = ~(4'b0001 << digit_idx_q);
        seg_d       = {1'b1, seg_decode(cur_nib)};
        if (!lit[digit_idx_q]) begin
            an_d  = 4'b1111;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 8'hFF;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
`default_nettype wire
